// File: rtl/operand_fetch_pkg.sv
// Shared constants and payload types for the operand fetch (decode-to-execute) stage.
package operand_fetch_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned AW     = 3;
    localparam int unsigned NREG   = 1 << AW;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [AW-1:0]     reg_idx_t;

    localparam reg_idx_t R0 = '0;

    // Operand-B select encoding, shared with the downstream 2:1 mux
    localparam logic OPB_REG = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    typedef struct packed {
        word_t    a;
        word_t    b;
        word_t    imm;
        logic     sel;
        reg_idx_t rd;
    } idex_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decoded-instruction input, write-back port and ID/EX output bundle of the operand fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic     in_valid;
    logic     in_ready;
    reg_idx_t in_rs;
    reg_idx_t in_rt;
    reg_idx_t in_rd;
    word_t    in_imm;
    logic     in_use_imm;

    logic     wb_en;
    reg_idx_t wb_addr;
    word_t    wb_data;

    logic     out_valid;
    logic     out_ready;
    word_t    out_a;
    word_t    out_b;
    word_t    out_imm;
    logic     out_sel;
    reg_idx_t out_rd;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_a, out_b, out_imm, out_sel, out_rd
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_a, out_b, out_imm, out_sel, out_rd
    );

endinterface

// File: rtl/operand_fetch_regfile_2r1w.sv
// regfile_2r1w: 8x16 register file, one write port, two read ports with same-cycle write bypass.
module operand_fetch_regfile_2r1w
    import operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  reg_idx_t wr_addr,
    input  word_t    wr_data,
    input  reg_idx_t ra_addr,
    output word_t    ra_data_c,
    input  reg_idx_t rb_addr,
    output word_t    rb_data_c
);

    word_t mem [NREG];
    logic  wr_live_c;

    assign wr_live_c = wr_en && (wr_addr != R0);

    // R0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live_c) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ra_data_c = (ra_addr == R0)                   ? '0      :
                       (wr_live_c && wr_addr == ra_addr) ? wr_data : mem[ra_addr];
    assign rb_data_c = (rb_addr == R0)                   ? '0      :
                       (wr_live_c && wr_addr == rb_addr) ? wr_data : mem[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read plus ID/EX pipeline register with valid/ready handshake.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);

    word_t    rd_a_c;
    word_t    rd_b_c;
    idex_t    idex;
    logic     out_valid;
    reg_idx_t cap_rs;
    reg_idx_t cap_rt;
    logic     in_ready_c;
    logic     accept_c;
    logic     stall_c;
    logic     wb_live_c;

    operand_fetch_regfile_2r1w u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_addr),
        .wr_data   (bus.wb_data),
        .ra_addr   (bus.in_rs),
        .ra_data_c (rd_a_c),
        .rb_addr   (bus.in_rt),
        .rb_data_c (rd_b_c)
    );

    assign in_ready_c = !out_valid || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign stall_c    = out_valid && !bus.out_ready;
    assign wb_live_c  = bus.wb_en && (bus.wb_addr != R0);

    // ID/EX register; a stalled instruction tracks write-backs to its captured sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            idex      <= '0;
            cap_rs    <= R0;
            cap_rt    <= R0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            idex.a    <= rd_a_c;
            idex.b    <= rd_b_c;
            idex.imm  <= bus.in_imm;
            idex.sel  <= bus.in_use_imm ? OPB_IMM : OPB_REG;
            idex.rd   <= bus.in_rd;
            cap_rs    <= bus.in_rs;
            cap_rt    <= bus.in_rt;
        end else if (stall_c) begin
            if (wb_live_c && bus.wb_addr == cap_rs) begin
                idex.a <= bus.wb_data;
            end
            if (wb_live_c && bus.wb_addr == cap_rt) begin
                idex.b <= bus.wb_data;
            end
        end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid;
    assign bus.out_a     = idex.a;
    assign bus.out_b     = idex.b;
    assign bus.out_imm   = idex.imm;
    assign bus.out_sel   = idex.sel;
    assign bus.out_rd    = idex.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: scoreboard of expected ID/EX contents plus per-scenario checks.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        sel;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [8];
    bit          pushed_last;
    int          checks;
    int          errors;

    function automatic logic [15:0] mread(input logic [2:0] r);
        if (r == 3'd0) return 16'h0000;
        if (bus.wb_en === 1'b1 && bus.wb_addr == r) return bus.wb_data;
        return model[r];
    endfunction

    // Reference model and scoreboard, evaluated on every falling edge
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                for (int i = 0; i < 8; i++) model[i] = 16'h0000;
                pushed_last = 1'b0;
            end else begin
                if (pushed_last) begin
                    checks++;
                    if (bus.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL latency: out_valid=%b, required 1 one cycle after accept", bus.out_valid);
                    end
                end
                checks++;
                if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                    errors++;
                    $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b", bus.in_ready, bus.out_valid, bus.out_ready);
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: output rd=%0d with nothing expected", bus.out_rd);
                    end else begin
                        e = q.pop_front();
                        if ({bus.out_a, bus.out_b, bus.out_imm, bus.out_sel, bus.out_rd} !== {e.a, e.b, e.imm, e.sel, e.rd}) begin
                            errors++;
                            $display("FAIL sb_data: got a=%h b=%h imm=%h sel=%b rd=%0d, required a=%h b=%h imm=%h sel=%b rd=%0d",
                                     bus.out_a, bus.out_b, bus.out_imm, bus.out_sel, bus.out_rd, e.a, e.b, e.imm, e.sel, e.rd);
                        end
                    end
                end else if (bus.out_valid === 1'b1 && q.size() > 0 && bus.wb_en === 1'b1 && bus.wb_addr != 3'd0) begin
                    e = q[0];
                    if (bus.wb_addr == e.rs) e.a = bus.wb_data;
                    if (bus.wb_addr == e.rt) e.b = bus.wb_data;
                    q[0] = e;
                end
                pushed_last = 1'b0;
                if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                    e.rs  = bus.in_rs;
                    e.rt  = bus.in_rt;
                    e.rd  = bus.in_rd;
                    e.a   = mread(bus.in_rs);
                    e.b   = mread(bus.in_rt);
                    e.imm = bus.in_imm;
                    e.sel = bus.in_use_imm;
                    q.push_back(e);
                    pushed_last = 1'b1;
                end
                if (bus.wb_en === 1'b1 && bus.wb_addr != 3'd0) model[bus.wb_addr] = bus.wb_data;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [15:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        step();
        bus.wb_en   = 1'b0;
    endtask

    // Present one instruction and hold it until the stage accepts it (bounded)
    task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                         input logic [15:0] imm, input logic use_imm);
        bit ok;
        bus.in_valid   = 1'b1;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_rd      = rd;
        bus.in_imm     = imm;
        bus.in_use_imm = use_imm;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed %b, required 1 within 20 cycles", bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_rs      = '0;
        bus.in_rt      = '0;
        bus.in_rd      = '0;
        bus.in_imm     = '0;
        bus.in_use_imm = 1'b0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
        bus.out_ready  = 1'b1;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
        checks++;
        if ({bus.out_a, bus.out_b, bus.out_imm} !== 48'h0) begin
            errors++; $display("FAIL reset_data: got a=%h b=%h imm=%h, required 0", bus.out_a, bus.out_b, bus.out_imm);
        end
        checks++;
        if ({bus.out_sel, bus.out_rd} !== 4'h0) begin
            errors++; $display("FAIL reset_sel_rd: got sel=%b rd=%0d, required 0", bus.out_sel, bus.out_rd);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_read_all();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 3'(i), 3'(i), 16'(i), 1'b0);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_a !== 16'h0 || bus.out_b !== 16'h0 || bus.out_rd !== 3'(i)) begin
                errors++;
                $display("FAIL read_r%0d: got v=%b a=%h b=%h rd=%0d, required v=1 a=0 b=0 rd=%0d",
                         i, bus.out_valid, bus.out_a, bus.out_b, bus.out_rd, i);
            end
            step();
        end
    endtask

    task automatic test_write_read();
        wb(3'd3, 16'hBEEF);
        issue(3'd3, 3'd0, 3'd1, 16'h0010, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.out_a, bus.out_b, bus.out_imm, bus.out_sel} !== {16'hBEEF, 16'h0000, 16'h0010, 1'b1}) begin
            errors++;
            $display("FAIL write_read: got a=%h b=%h imm=%h sel=%b, required a=beef b=0000 imm=0010 sel=1",
                     bus.out_a, bus.out_b, bus.out_imm, bus.out_sel);
        end
        step();
    endtask

    task automatic test_bypass();
        bus.wb_en   = 1'b1;
        bus.wb_addr = 3'd5;
        bus.wb_data = 16'h1234;
        issue(3'd5, 3'd5, 3'd2, 16'h0000, 1'b0);
        bus.wb_en   = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_a !== 16'h1234 || bus.out_b !== 16'h1234) begin
            errors++; $display("FAIL bypass: got a=%h b=%h, required 1234", bus.out_a, bus.out_b);
        end
        step();
        wb(3'd0, 16'hFFFF);
        issue(3'd0, 3'd0, 3'd3, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
            errors++; $display("FAIL r0_write: got a=%h b=%h, required 0000", bus.out_a, bus.out_b);
        end
        step();
    endtask

    task automatic test_stall();
        wb(3'd2, 16'h0001);
        bus.out_ready = 1'b0;
        issue(3'd1, 3'd2, 3'd6, 16'h0055, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_b !== 16'h0001 ||
                bus.out_imm !== 16'h0055 || bus.out_rd !== 3'd6) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b rdy=%b b=%h imm=%h rd=%0d, required v=1 rdy=0 b=0001 imm=0055 rd=6",
                         k, bus.out_valid, bus.in_ready, bus.out_b, bus.out_imm, bus.out_rd);
            end
            step();
        end
        wb(3'd2, 16'h00AA);
        @(negedge clk);
        checks++;
        if (bus.out_b !== 16'h00AA || bus.out_a !== 16'h0000) begin
            errors++; $display("FAIL stall_refresh: got a=%h b=%h, required a=0000 b=00aa", bus.out_a, bus.out_b);
        end
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, required 1", bus.in_ready); end
        step();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b, required 0", bus.out_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  rds [4] = '{3'd7, 3'd4, 3'd2, 3'd5};
        logic [2:0]  rss [4] = '{3'd3, 3'd5, 3'd2, 3'd0};
        logic [2:0]  rts [4] = '{3'd2, 3'd3, 3'd5, 3'd4};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_rs      = rss[i];
            bus.in_rt      = rts[i];
            bus.in_rd      = rds[i];
            bus.in_imm     = 16'(16'h0100 + i);
            bus.in_use_imm = 1'(i);
            if (i == 3) begin
                bus.wb_en   = 1'b1;
                bus.wb_addr = 3'd4;
                bus.wb_data = 16'h4444;
            end
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_rd !== rds[i-1]) begin
                    errors++;
                    $display("FAIL stream%0d: got v=%b rd=%0d, required v=1 rd=%0d", i, bus.out_valid, bus.out_rd, rds[i-1]);
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== rds[3] || bus.out_b !== 16'h4444) begin
            errors++;
            $display("FAIL stream_last: got v=%b rd=%0d b=%h, required v=1 rd=%0d b=4444", bus.out_valid, bus.out_rd, bus.out_b, rds[3]);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b, required 0", bus.out_valid); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        issue(3'd3, 3'd0, 3'd1, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_a !== 16'hBEEF) begin
            errors++; $display("FAIL pre_reset: got v=%b a=%h, required v=1 a=beef", bus.out_valid, bus.out_a);
        end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_a !== 16'h0000) begin
            errors++; $display("FAIL async_reset: got v=%b a=%h, required v=0 a=0000", bus.out_valid, bus.out_a);
        end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        issue(3'd3, 3'd2, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
            errors++; $display("FAIL post_reset_regs: got a=%h b=%h, required 0000", bus.out_a, bus.out_b);
        end
        step();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pushed_last = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_read_all();
        test_write_read();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d expected outputs never produced, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
